// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit 7-segment bus: synchronizes the pins,
// captures each digit once it has been stable, and assembles complete 16-bit frames.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  seg_n,
  input  logic [3:0]  dig_en,
  output logic [15:0] value,
  output logic [3:0]  dots,
  output logic        frame_valid,
  output logic [3:0]  err_digits,
  output logic        stale
);

  localparam int             IW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     RUN_SAT   = 4'(STABLE_CYCLES);
  localparam logic [11:0]    W_BLANK   = 12'h0FF;

  // Word layout is {dig_en, seg_n}; w_q is the second synchronizer stage.
  logic [11:0] sync1_q, w_q;
  logic [3:0]  run_q, run_d;
  logic        w_change;
  logic [3:0]  cap_dig;
  logic [7:0]  cap_seg;
  logic        dig_onehot;
  logic        capture;
  logic [4:0]  dec;

  logic [15:0] slot_nib_q, slot_nib_d;
  logic [3:0]  slot_dot_q, slot_dot_d;
  logic [3:0]  slot_err_q, slot_err_d;
  logic [3:0]  slot_we;
  logic [3:0]  seen_q, seen_d;
  logic [IW-1:0] idle_q, idle_d;
  logic        load;

  logic [15:0] value_q, value_d;
  logic [3:0]  dots_q, dots_d;
  logic [3:0]  err_q, err_d;
  logic        fv_q;
  logic        stale_q, stale_d;

  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40:   r = {1'b0, 4'h0};
      7'h79:   r = {1'b0, 4'h1};
      7'h24:   r = {1'b0, 4'h2};
      7'h30:   r = {1'b0, 4'h3};
      7'h19:   r = {1'b0, 4'h4};
      7'h12:   r = {1'b0, 4'h5};
      7'h02:   r = {1'b0, 4'h6};
      7'h78:   r = {1'b0, 4'h7};
      7'h00:   r = {1'b0, 4'h8};
      7'h10:   r = {1'b0, 4'h9};
      7'h08:   r = {1'b0, 4'hA};
      7'h03:   r = {1'b0, 4'hB};
      7'h46:   r = {1'b0, 4'hC};
      7'h21:   r = {1'b0, 4'hD};
      7'h06:   r = {1'b0, 4'hE};
      7'h0E:   r = {1'b0, 4'hF};
      default: r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= W_BLANK;
      w_q     <= W_BLANK;
      run_q   <= 4'd1;
    end else begin
      sync1_q <= {dig_en, seg_n};
      w_q     <= sync1_q;
      run_q   <= run_d;
    end
  end

  // sync1_q is the word w will hold after this edge, so capture acts on it directly.
  assign w_change   = (sync1_q != w_q);
  assign cap_dig    = sync1_q[11:8];
  assign cap_seg    = sync1_q[7:0];
  assign dig_onehot = (cap_dig != 4'd0) && ((cap_dig & (cap_dig - 4'd1)) == 4'd0);

  always_comb begin
    run_d = run_q;
    if (w_change) begin
      run_d = 4'd1;
    end else if (run_q != RUN_SAT) begin
      run_d = run_q + 4'd1;
    end
  end

  assign capture = (run_d == RUN_SAT) && (w_change || (run_q != RUN_SAT)) && dig_onehot;
  assign dec     = decode_seg(cap_seg[6:0]);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      assign slot_we[gi] = capture & cap_dig[gi];
      assign slot_nib_d[gi*4 +: 4] = slot_we[gi] ? dec[3:0]   : slot_nib_q[gi*4 +: 4];
      assign slot_dot_d[gi]        = slot_we[gi] ? ~cap_seg[7] : slot_dot_q[gi];
      assign slot_err_d[gi]        = slot_we[gi] ? dec[4]     : slot_err_q[gi];
    end
  endgenerate

  assign load = (seen_q == 4'hF);

  always_comb begin
    seen_d  = seen_q;
    stale_d = stale_q;
    idle_d  = idle_q;
    value_d = value_q;
    dots_d  = dots_q;
    err_d   = err_q;
    if (load) begin
      value_d = slot_nib_q;
      dots_d  = slot_dot_q;
      err_d   = slot_err_q;
      seen_d  = 4'd0;
      stale_d = 1'b0;
    end
    // A capture on the load edge lands in the freshly cleared frame and beats a timeout.
    if (capture) begin
      seen_d = seen_d | cap_dig;
      idle_d = '0;
    end else if (idle_q == IDLE_LAST) begin
      seen_d  = 4'd0;
      stale_d = 1'b1;
      idle_d  = '0;
    end else begin
      idle_d = idle_q + IW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_nib_q <= 16'd0;
      slot_dot_q <= 4'd0;
      slot_err_q <= 4'd0;
      seen_q     <= 4'd0;
      idle_q     <= '0;
      value_q    <= 16'd0;
      dots_q     <= 4'd0;
      err_q      <= 4'd0;
      fv_q       <= 1'b0;
      stale_q    <= 1'b1;
    end else begin
      slot_nib_q <= slot_nib_d;
      slot_dot_q <= slot_dot_d;
      slot_err_q <= slot_err_d;
      seen_q     <= seen_d;
      idle_q     <= idle_d;
      value_q    <= value_d;
      dots_q     <= dots_d;
      err_q      <= err_d;
      fv_q       <= load;
      stale_q    <= stale_d;
    end
  end

  assign value       = value_q;
  assign dots        = dots_q;
  assign err_digits  = err_q;
  assign frame_valid = fv_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans digit patterns onto the bus and
// checks frames, error flags, staleness, timeout and reset behaviour.
module tb_seg7_scan_decoder;

  localparam int TMO = 200;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  seg_n;
  logic [3:0]  dig_en;
  logic [15:0] value;
  logic [3:0]  dots;
  logic        frame_valid;
  logic [3:0]  err_digits;
  logic        stale;

  int checks = 0;
  int passed = 0;
  int fv_count = 0;
  int wide_count = 0;
  int cyc = 0;
  bit prev_fv = 0;
  int stamps[$];

  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_decoder #(.STABLE_CYCLES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N), .seg_n(seg_n), .dig_en(dig_en),
    .value(value), .dots(dots), .frame_valid(frame_valid),
    .err_digits(err_digits), .stale(stale)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc++;
    #2;
    if (frame_valid) begin
      fv_count++;
      stamps.push_back(cyc);
      if (prev_fv) wide_count++;
    end
    prev_fv = frame_valid;
  end

  task automatic show_digit(input int idx, input logic [6:0] p, input bit dot, input int dwell);
    seg_n  = {~dot, p};
    dig_en = 4'b0001 << idx;
    repeat (dwell) @(negedge CLK);
  endtask

  task automatic blank(input int n);
    seg_n  = 8'hFF;
    dig_en = 4'b0000;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset;
    RST_N = 0;
    seg_n = 8'hFF;
    dig_en = 4'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1;
    @(negedge CLK);
    checks++; if (value !== 16'h0) $display("FAIL reset_value: got %h expected %h", value, 16'h0); else passed++;
    checks++; if (dots !== 4'h0) $display("FAIL reset_dots: got %b expected %b", dots, 4'h0); else passed++;
    checks++; if (err_digits !== 4'h0) $display("FAIL reset_err: got %b expected %b", err_digits, 4'h0); else passed++;
    checks++; if (frame_valid !== 1'b0) $display("FAIL reset_fv: got %b expected 0", frame_valid); else passed++;
    checks++; if (stale !== 1'b1) $display("FAIL reset_stale: got %b expected 1", stale); else passed++;
    $display("reset: value=%h dots=%b err=%b stale=%b", value, dots, err_digits, stale);
  endtask

  task automatic test_short_dwell;
    int fv0;
    fv0 = fv_count;
    for (int i = 0; i < 250; i++) show_digit(i % 4, pat[i % 16], 1'b0, 1);
    blank(4);
    checks++; if (fv_count !== fv0) $display("FAIL short_dwell_frames: got %0d expected %0d", fv_count - fv0, 0); else passed++;
    checks++; if (stale !== 1'b1) $display("FAIL short_dwell_stale: got %b expected 1", stale); else passed++;
    $display("short_dwell: frames=%0d stale=%b", fv_count - fv0, stale);
  endtask

  task automatic test_scan_basic;
    int fv0;
    fv0 = fv_count;
    show_digit(3, pat[1], 1'b0, 4);
    show_digit(2, pat[2], 1'b0, 4);
    show_digit(1, pat[3], 1'b0, 4);
    seg_n  = {1'b0, pat[4]};
    dig_en = 4'b0001;
    @(posedge CLK); @(posedge CLK); @(posedge CLK); #1;
    checks++; if (frame_valid !== 1'b0) $display("FAIL scan_fv_early: got %b expected 0", frame_valid); else passed++;
    checks++; if (stale !== 1'b1) $display("FAIL scan_stale_before: got %b expected 1", stale); else passed++;
    @(posedge CLK); #1;
    checks++; if (frame_valid !== 1'b1) $display("FAIL scan_fv_pulse: got %b expected 1", frame_valid); else passed++;
    checks++; if (value !== 16'h1234) $display("FAIL scan_value: got %h expected %h", value, 16'h1234); else passed++;
    @(posedge CLK); #1;
    checks++; if (frame_valid !== 1'b0) $display("FAIL scan_fv_width: got %b expected 0", frame_valid); else passed++;
    @(negedge CLK);
    blank(6);
    checks++; if (dots !== 4'b0001) $display("FAIL scan_dots: got %b expected %b", dots, 4'b0001); else passed++;
    checks++; if (err_digits !== 4'b0000) $display("FAIL scan_err: got %b expected %b", err_digits, 4'b0000); else passed++;
    checks++; if (stale !== 1'b0) $display("FAIL scan_stale_after: got %b expected 0", stale); else passed++;
    checks++; if (fv_count - fv0 !== 1) $display("FAIL scan_frames: got %0d expected 1", fv_count - fv0); else passed++;
    $display("scan_basic: value=%h dots=%b err=%b stale=%b frames=%0d", value, dots, err_digits, stale, fv_count - fv0);
  endtask

  task automatic test_bad_pattern;
    show_digit(3, pat[10], 1'b0, 4);
    show_digit(2, 7'h7F, 1'b0, 4);
    show_digit(1, pat[12], 1'b0, 4);
    show_digit(0, pat[13], 1'b0, 4);
    blank(4);
    checks++; if (value !== 16'hA0CD) $display("FAIL bad_value: got %h expected %h", value, 16'hA0CD); else passed++;
    checks++; if (err_digits !== 4'b0100) $display("FAIL bad_err: got %b expected %b", err_digits, 4'b0100); else passed++;
    checks++; if (dots !== 4'b0000) $display("FAIL bad_dots: got %b expected %b", dots, 4'b0000); else passed++;
    $display("bad_pattern: value=%h err=%b", value, err_digits);
  endtask

  task automatic test_timeout;
    int fv0;
    fv0 = fv_count;
    show_digit(3, pat[1], 1'b0, 4);
    show_digit(2, pat[2], 1'b0, 4);
    show_digit(1, pat[3], 1'b0, 4);
    blank(TMO + 5);
    checks++; if (stale !== 1'b1) $display("FAIL timeout_stale: got %b expected 1", stale); else passed++;
    checks++; if (value !== 16'hA0CD) $display("FAIL timeout_value_kept: got %h expected %h", value, 16'hA0CD); else passed++;
    // Only digit 0 after timeout: a frame here would mean seen survived the timeout.
    show_digit(0, pat[15], 1'b0, 4);
    blank(10);
    checks++; if (fv_count !== fv0) $display("FAIL timeout_seen_cleared: got %0d frames expected 0", fv_count - fv0); else passed++;
    show_digit(3, pat[15], 1'b0, 4);
    show_digit(2, pat[0], 1'b0, 4);
    show_digit(1, pat[0], 1'b0, 4);
    blank(5);
    checks++; if (value !== 16'hF00F) $display("FAIL timeout_rescan_value: got %h expected %h", value, 16'hF00F); else passed++;
    checks++; if (stale !== 1'b0) $display("FAIL timeout_rescan_stale: got %b expected 0", stale); else passed++;
    checks++; if (err_digits !== 4'b0000) $display("FAIL timeout_rescan_err: got %b expected %b", err_digits, 4'b0000); else passed++;
    $display("timeout: value=%h stale=%b frames=%0d", value, stale, fv_count - fv0);
  endtask

  task automatic test_reset_mid_frame;
    int fv0;
    show_digit(3, pat[9], 1'b1, 4);
    show_digit(2, pat[9], 1'b1, 4);
    blank(2);
    RST_N = 0;
    #1;
    checks++; if (value !== 16'h0) $display("FAIL midrst_value: got %h expected %h", value, 16'h0); else passed++;
    checks++; if (dots !== 4'h0) $display("FAIL midrst_dots: got %b expected %b", dots, 4'h0); else passed++;
    checks++; if (err_digits !== 4'h0) $display("FAIL midrst_err: got %b expected %b", err_digits, 4'h0); else passed++;
    checks++; if (frame_valid !== 1'b0) $display("FAIL midrst_fv: got %b expected 0", frame_valid); else passed++;
    checks++; if (stale !== 1'b1) $display("FAIL midrst_stale: got %b expected 1", stale); else passed++;
    @(negedge CLK);
    RST_N = 1;
    @(negedge CLK);
    fv0 = fv_count;
    show_digit(1, pat[7], 1'b0, 4);
    show_digit(0, pat[8], 1'b0, 4);
    blank(4);
    checks++; if (fv_count !== fv0) $display("FAIL midrst_carry: got %0d frames expected 0", fv_count - fv0); else passed++;
    show_digit(3, pat[5], 1'b0, 4);
    show_digit(2, pat[6], 1'b0, 4);
    blank(5);
    checks++; if (value !== 16'h5678) $display("FAIL midrst_value_after: got %h expected %h", value, 16'h5678); else passed++;
    checks++; if (dots !== 4'b0000) $display("FAIL midrst_dots_after: got %b expected %b", dots, 4'b0000); else passed++;
    $display("reset_mid_frame: value=%h dots=%b frames=%0d", value, dots, fv_count - fv0);
  endtask

  task automatic test_back_to_back;
    int fv0;
    int gap;
    fv0 = fv_count;
    wide_count = 0;
    stamps.delete();
    for (int f = 0; f < 5; f++) begin
      show_digit(3, pat[9], 1'b0, 4);
      show_digit(2, pat[8], 1'b0, 4);
      show_digit(1, pat[7], 1'b0, 4);
      show_digit(0, pat[6], 1'b0, 4);
    end
    blank(6);
    checks++; if (fv_count - fv0 !== 5) $display("FAIL b2b_frames: got %0d expected 5", fv_count - fv0); else passed++;
    checks++; if (wide_count !== 0) $display("FAIL b2b_width: got %0d wide pulses expected 0", wide_count); else passed++;
    checks++; if (value !== 16'h9876) $display("FAIL b2b_value: got %h expected %h", value, 16'h9876); else passed++;
    for (int i = 1; i < stamps.size(); i++) begin
      gap = stamps[i] - stamps[i-1];
      checks++; if (gap !== 16) $display("FAIL b2b_gap%0d: got %0d cycles expected 16", i, gap); else passed++;
    end
    $display("back_to_back: frames=%0d value=%h wide=%0d", fv_count - fv0, value, wide_count);
  endtask

  initial begin
    RST_N = 0;
    seg_n = 8'hFF;
    dig_en = 4'b0;
    test_reset;
    test_short_dwell;
    test_scan_basic;
    test_bad_pattern;
    test_timeout;
    test_reset_mid_frame;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side decoder for the multiplexed 4-digit 7-segment display bus. It synchronizes the active-low segment lines and the per-digit enables, and filters out glitches at digit changeover. It maps each stable segment pattern back to its hex nibble and dot state, then assembles the four digits into one 16-bit frame. It sits on the pins of a board that observes or loops back a display driver, and is used for self-test and for reading legacy display-only equipment.

## Interface
- STABLE_CYCLES, 2: number of consecutive synchronized samples a word (seg_n, dig_en) must hold before capture; legal 1..15.
- TIMEOUT_CYCLES, 65536: cycles without any capture before the partial frame is discarded and stale is set; legal 2..2^24.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- seg_n  in  8  segment bus, active-low. Bits [6:0] are segments a..g, bit0 = a. Bit7 = dot, active-low.
- dig_en  in  4  digit enables, active-high, one-hot. dig_en[3] = most significant digit (value[15:12]), dig_en[0] = value[3:0].
- value  out  16  last complete frame, hex nibbles.
- dots  out  4  dot state per digit of the last frame, 1 = lit; same bit order as dig_en.
- frame_valid  out  1  one-cycle pulse when value/dots/err_digits update.
- err_digits  out  4  per digit: 1 = pattern in last frame matched no table entry.
- stale  out  1  level; 1 = no complete frame since reset or since last timeout.

## Operation
- Input path: seg_n and dig_en pass through a 2-flop synchronizer, giving a 12-bit word w.
- Run counter: resets to 1 on an edge where w changes, otherwise increments and saturates at STABLE_CYCLES.
- Capture: occurs on the edge where the run counter reaches exactly STABLE_CYCLES, and only if dig_en in w is one-hot. A zero or multi-hot dig_en is a blanking interval and is never captured. Each run captures at most once. A new run on the same digit (after blanking or a pattern change) captures again and overwrites.
- Decode of seg_n[6:0]: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F (hex). Any other pattern → nibble 0, slot error = 1. Dot = ~seg_n[7].
- Slot store: 4 slots × {nibble, dot, err}, plus a seen[3:0] mask. A capture writes the slot and sets its seen bit.
- Frame completion: when seen becomes 4'b1111, the next edge loads value, dots and err_digits from the slots, pulses frame_valid, clears stale, and clears seen.
- Timeout: an idle counter resets on every capture and otherwise increments. On reaching TIMEOUT_CYCLES it clears seen, sets stale = 1, and restarts. value, dots and err_digits keep their last contents.
- Simultaneous events:
  - A capture and a timeout on the same edge: the capture wins and the idle counter resets.
  - A capture landing on the frame-load edge goes into the new, cleared frame: seen shows only that slot.
- Reset (any time, including mid-frame): value = 0, dots = 0, err_digits = 0, frame_valid = 0, stale = 1. Synchronizers cleared to seg_n = FF, dig_en = 0 (blank). Run counter = 1, seen = 0, idle counter = 0.

## Timing
- A word first present at the pins before edge 0 reaches w at edge 1 and is captured at edge STABLE_CYCLES. With default 2, that is edge 2.
- If that capture completes the frame, frame_valid is high for exactly one cycle, from edge STABLE_CYCLES+1 to the next edge; value is updated at that same edge.
- A pin glitch shorter than STABLE_CYCLES cycles (as seen after synchronization) never captures.
- Minimum dwell per digit for reliable capture: STABLE_CYCLES + 1 cycles plus any blanking.
- With a 1-cycle dwell and STABLE_CYCLES = 1, every digit is captured.
- Maximum frame rate: one frame per 4 captures.

## Test plan
- Scan 1,2,3,4 (msd first), dwell 4 cycles each, dots only on digit 0 -> one frame_valid; value = 16'h1234, dots = 4'b0001, err_digits = 0, stale 1→0.
- Dwell of 1 cycle per digit with STABLE_CYCLES = 2 -> no capture, no frame_valid; stale remains 1 and goes through one timeout.
- Digit 2 shows pattern 7'h7F (blank) within a valid scan of A,B,C,D -> value = 16'hA0CD, err_digits = 4'b0100.
- Three digits scanned, then bus held blank for TIMEOUT_CYCLES -> stale = 1, seen cleared. A later full scan of F,0,0,F -> value = 16'hF00F from that scan only.
- Assert RST_N low for 1 cycle mid-frame after 2 captures -> all outputs at reset values. The next full scan of 5,6,7,8 -> value = 16'h5678 with no carry-over.
- Continuous scan of 9,8,7,6 for 5 frames -> exactly 5 frame_valid pulses, each 1 cycle wide, spaced by 4 digit dwells.
